// File: rtl/exp_swap_align_pipe.sv
// Two-stage operand ordering ahead of the FP add/sub aligner: orders (sign, exp, mantissa)
// by magnitude and computes the saturated alignment shift. Define EXP_SWAP_TIEBREAK_MAN_EN to break exponent ties on mantissa.
module exp_swap_align_pipe #(
    parameter int SIZE_EXP = 8,
    parameter int SIZE_MAN = 24,
    localparam int SHIFT_SAT  = SIZE_MAN + 2,
    localparam int SIZE_SHIFT = $clog2(SHIFT_SAT + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_sign_a,
    input  logic                  i_sign_b,
    input  logic [SIZE_EXP-1:0]   i_exp_a,
    input  logic [SIZE_EXP-1:0]   i_exp_b,
    input  logic [SIZE_MAN-1:0]   i_man_a,
    input  logic [SIZE_MAN-1:0]   i_man_b,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_compare,
    output logic                  o_sign_greater,
    output logic                  o_sign_less,
    output logic [SIZE_EXP-1:0]   o_exp_greater,
    output logic [SIZE_MAN-1:0]   o_man_greater,
    output logic [SIZE_MAN-1:0]   o_man_less,
    output logic [SIZE_SHIFT-1:0] o_shift_amt,
    output logic                  o_shift_sat,
    output logic                  o_exp_eq
);

    localparam logic [SIZE_EXP-1:0]   SAT_EXP   = SIZE_EXP'(SHIFT_SAT);
    localparam logic [SIZE_SHIFT-1:0] SAT_SHIFT = SIZE_SHIFT'(SHIFT_SAT);

    function automatic logic is_sat(input logic [SIZE_EXP-1:0] diff);
        return diff > SAT_EXP;
    endfunction

    function automatic logic [SIZE_SHIFT-1:0] sat_shift(input logic [SIZE_EXP-1:0] diff);
        return is_sat(diff) ? SAT_SHIFT : SIZE_SHIFT'(diff);
    endfunction

    logic                vld_p1, cmp_p1, eq_p1, sign_g_p1, sign_l_p1;
    logic [SIZE_EXP-1:0] exp_g_p1, exp_l_p1, diff_p1;
    logic [SIZE_MAN-1:0] man_g_p1, man_l_p1;

    logic                  vld_p2, cmp_p2, eq_p2, sign_g_p2, sign_l_p2, sat_p2;
    logic [SIZE_EXP-1:0]   exp_g_p2;
    logic [SIZE_MAN-1:0]   man_g_p2, man_l_p2;
    logic [SIZE_SHIFT-1:0] shift_p2;

    logic exp_lt, exp_eq, swap, load_p1, load_p2, take_in;

    always_comb begin
        exp_lt = i_exp_a < i_exp_b;
        exp_eq = i_exp_a == i_exp_b;
`ifdef EXP_SWAP_TIEBREAK_MAN_EN
        swap   = exp_lt | (exp_eq & (i_man_a < i_man_b));
`else
        swap   = exp_lt;
`endif
    end

    assign load_p2 = !vld_p2 | i_ready;
    assign load_p1 = !vld_p1 | load_p2;
    assign o_ready = !vld_p1 | !vld_p2 | i_ready;
    assign take_in = i_valid & o_ready;

    // Stage 1: compare and swap
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_p1    <= 1'b0;
            cmp_p1    <= 1'b0;
            eq_p1     <= 1'b0;
            sign_g_p1 <= 1'b0;
            sign_l_p1 <= 1'b0;
            exp_g_p1  <= '0;
            exp_l_p1  <= '0;
            man_g_p1  <= '0;
            man_l_p1  <= '0;
        end else begin
            if (load_p1) vld_p1 <= i_valid;
            if (take_in) begin
                cmp_p1    <= swap;
                eq_p1     <= exp_eq;
                sign_g_p1 <= swap ? i_sign_b : i_sign_a;
                sign_l_p1 <= swap ? i_sign_a : i_sign_b;
                exp_g_p1  <= swap ? i_exp_b  : i_exp_a;
                exp_l_p1  <= swap ? i_exp_a  : i_exp_b;
                man_g_p1  <= swap ? i_man_b  : i_man_a;
                man_l_p1  <= swap ? i_man_a  : i_man_b;
            end
        end
    end

    // Ordering guarantees exp_g >= exp_l, so the difference never wraps
    assign diff_p1 = exp_g_p1 - exp_l_p1;

    // Stage 2: difference and saturation
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_p2    <= 1'b0;
            cmp_p2    <= 1'b0;
            eq_p2     <= 1'b0;
            sign_g_p2 <= 1'b0;
            sign_l_p2 <= 1'b0;
            sat_p2    <= 1'b0;
            exp_g_p2  <= '0;
            man_g_p2  <= '0;
            man_l_p2  <= '0;
            shift_p2  <= '0;
        end else begin
            if (load_p2) vld_p2 <= vld_p1;
            if (load_p2 && vld_p1) begin
                cmp_p2    <= cmp_p1;
                eq_p2     <= eq_p1;
                sign_g_p2 <= sign_g_p1;
                sign_l_p2 <= sign_l_p1;
                sat_p2    <= is_sat(diff_p1);
                exp_g_p2  <= exp_g_p1;
                man_g_p2  <= man_g_p1;
                man_l_p2  <= man_l_p1;
                shift_p2  <= sat_shift(diff_p1);
            end
        end
    end

    assign o_valid        = vld_p2;
    assign o_compare      = cmp_p2;
    assign o_sign_greater = sign_g_p2;
    assign o_sign_less    = sign_l_p2;
    assign o_exp_greater  = exp_g_p2;
    assign o_man_greater  = man_g_p2;
    assign o_man_less     = man_l_p2;
    assign o_shift_amt    = shift_p2;
    assign o_shift_sat    = sat_p2;
    assign o_exp_eq       = eq_p2;

endmodule

// File: tb/tb_exp_swap_align_pipe.sv
// Scoreboard bench for exp_swap_align_pipe: expected results queued on input handshake,
// compared on output handshake; also checks reset, stall hold, latency and throughput.
module tb_exp_swap_align_pipe;

    typedef struct packed {
        logic        cmp;
        logic        sg;
        logic        sl;
        logic [7:0]  eg;
        logic [23:0] mg;
        logic [23:0] ml;
        logic [4:0]  sh;
        logic        sat;
        logic        eq;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0, i_ready = 1'b1;
    logic        i_sign_a = 1'b0, i_sign_b = 1'b0;
    logic [7:0]  i_exp_a = '0, i_exp_b = '0;
    logic [23:0] i_man_a = '0, i_man_b = '0;
    logic        o_ready, o_valid, o_compare, o_sign_greater, o_sign_less, o_shift_sat, o_exp_eq;
    logic [7:0]  o_exp_greater;
    logic [23:0] o_man_greater, o_man_less;
    logic [4:0]  o_shift_amt;

    res_t dut_r, held;
    res_t scb[$];
    int   n_cmp = 0, n_bad = 0;
    logic stall_prev = 1'b0;
    logic last_ovalid = 1'b0;

    assign dut_r = {o_compare, o_sign_greater, o_sign_less, o_exp_greater,
                    o_man_greater, o_man_less, o_shift_amt, o_shift_sat, o_exp_eq};

    exp_swap_align_pipe dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_sign_a(i_sign_a), .i_sign_b(i_sign_b), .i_exp_a(i_exp_a), .i_exp_b(i_exp_b),
        .i_man_a(i_man_a), .i_man_b(i_man_b), .o_valid(o_valid), .i_ready(i_ready),
        .o_compare(o_compare), .o_sign_greater(o_sign_greater), .o_sign_less(o_sign_less),
        .o_exp_greater(o_exp_greater), .o_man_greater(o_man_greater), .o_man_less(o_man_less),
        .o_shift_amt(o_shift_amt), .o_shift_sat(o_shift_sat), .o_exp_eq(o_exp_eq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d compared, required completion", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic res_t model(input logic sa, input logic sb, input logic [7:0] ea,
                                   input logic [7:0] eb, input logic [23:0] ma, input logic [23:0] mb);
        res_t r;
        logic sw;
        logic [7:0] el, d;
        sw = ea < eb;
`ifdef EXP_SWAP_TIEBREAK_MAN_EN
        if (ea == eb) sw = ma < mb;
`endif
        r.cmp = sw;
        r.sg  = sw ? sb : sa;
        r.sl  = sw ? sa : sb;
        r.eg  = sw ? eb : ea;
        el    = sw ? ea : eb;
        r.mg  = sw ? mb : ma;
        r.ml  = sw ? ma : mb;
        d     = r.eg - el;
        r.sat = d > 8'd26;
        r.sh  = r.sat ? 5'd26 : d[4:0];
        r.eq  = ea == eb;
        return r;
    endfunction

    task automatic step(input logic v, input logic sa, input logic sb, input logic [7:0] ea,
                        input logic [7:0] eb, input logic [23:0] ma, input logic [23:0] mb,
                        input logic rdy, output logic acc);
        res_t e;
        @(negedge clk);
        i_valid = v; i_sign_a = sa; i_sign_b = sb; i_exp_a = ea; i_exp_b = eb;
        i_man_a = ma; i_man_b = mb; i_ready = rdy;
        #1;
        if (stall_prev) begin
            chk("stall_valid", 32'(o_valid), 1);
            chk("stall_hold", 32'(dut_r == held), 1);
        end
        acc = i_valid && o_ready;
        if (acc) scb.push_back(model(sa, sb, ea, eb, ma, mb));
        last_ovalid = o_valid;
        if (o_valid && i_ready) begin
            chk("sb_nonempty", 32'(scb.size() != 0), 1);
            if (scb.size() != 0) begin
                e = scb.pop_front();
                chk("compare",   32'(o_compare),      32'(e.cmp));
                chk("sign_g",    32'(o_sign_greater), 32'(e.sg));
                chk("sign_l",    32'(o_sign_less),    32'(e.sl));
                chk("exp_g",     32'(o_exp_greater),  32'(e.eg));
                chk("man_g",     32'(o_man_greater),  32'(e.mg));
                chk("man_l",     32'(o_man_less),     32'(e.ml));
                chk("shift_amt", 32'(o_shift_amt),    32'(e.sh));
                chk("shift_sat", 32'(o_shift_sat),    32'(e.sat));
                chk("exp_eq",    32'(o_exp_eq),       32'(e.eq));
            end
        end
        stall_prev = o_valid && !i_ready;
        held = dut_r;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 24'd0, 24'd0, 1'b1, acc);
    endtask

    task automatic send_rand(input logic rdy, output logic acc);
        logic [7:0] ea, eb;
        ea = 8'($urandom_range(0, 255));
        eb = ($urandom_range(0, 3) == 0) ? ea : 8'($urandom_range(0, 255));
        step(1'b1, 1'($urandom), 1'($urandom), ea, eb, 24'($urandom), 24'($urandom), rdy, acc);
    endtask

    // Directed patterns: {exp_a, exp_b, man_a, man_b}
    logic [7:0]  dir_ea [10] = '{8'd130, 8'd127, 8'd200, 8'd100, 8'd126, 8'd127, 8'd127, 8'd255, 8'd0,   8'd127};
    logic [7:0]  dir_eb [10] = '{8'd127, 8'd130, 8'd100, 8'd200, 8'd100, 8'd100, 8'd127, 8'd0,   8'd255, 8'd127};
    logic [23:0] dir_ma [10] = '{24'h800001, 24'hA00000, 24'hFFFFFF, 24'h800000, 24'h900000,
                                 24'hB00000, 24'h800000, 24'h123456, 24'h000001, 24'hC00000};
    logic [23:0] dir_mb [10] = '{24'hA00000, 24'h800001, 24'h800000, 24'hFFFFFF, 24'h800000,
                                 24'h800000, 24'hC00000, 24'h654321, 24'hFFFFFE, 24'h800000};

    initial begin
        logic acc;
        int   i, cyc, first;

        // Reset state
        rst = 1'b1;
        i_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_o_valid", 32'(o_valid), 0);
        chk("rst_o_ready", 32'(o_ready), 1);
        chk("rst_outs_zero", 32'(dut_r == '0), 1);
        i_valid = 1'b0;
        rst = 1'b0;

        // Directed order / saturation / tie cases
        for (int k = 0; k < 10; k++)
            step(1'b1, 1'(k & 1), 1'((k >> 1) & 1), dir_ea[k], dir_eb[k], dir_ma[k], dir_mb[k], 1'b1, acc);
        idle(4);
        chk("directed_drain", scb.size(), 0);

        // Backpressure: 8 pairs, downstream stalled for 3 cycles mid-stream
        i = 0;
        cyc = 0;
        while (i < 8 && cyc < 100) begin
            send_rand(!(cyc >= 3 && cyc < 6), acc);
            if (acc) i++;
            cyc++;
        end
        chk("bp_all_accepted", i, 8);
        idle(4);
        chk("bp_drain", scb.size(), 0);

        // Throughput from an empty pipe
        for (int k = 0; k < 16; k++) begin
            send_rand(1'b1, acc);
            chk("tput_accept", 32'(acc), 1);
            chk("tput_valid", 32'(last_ovalid), 32'(k >= 2));
        end
        idle(4);
        chk("tput_drain", scb.size(), 0);

        // Reset mid-stream with two pairs in flight
        send_rand(1'b1, acc);
        send_rand(1'b1, acc);
        @(negedge clk);
        rst = 1'b1;
        i_valid = 1'b0;
        #1;
        chk("midrst_o_valid", 32'(o_valid), 0);
        chk("midrst_o_ready", 32'(o_ready), 1);
        chk("midrst_outs_zero", 32'(dut_r == '0), 1);
        scb.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        send_rand(1'b1, acc);
        first = 0;
        for (int k = 1; k <= 5; k++) begin
            idle(1);
            if (last_ovalid && first == 0) first = k;
        end
        chk("midrst_latency", first, 2);
        chk("midrst_drain", scb.size(), 0);

        // Random mix with random backpressure
        for (int k = 0; k < 60; k++) send_rand(1'($urandom_range(0, 3) != 0), acc);
        idle(6);
        chk("rand_drain", scb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
